// File: rtl/line_buf_pkg.sv
// Shared constants and pointer helper for pixel line buffers.
// Pointer wrap compares against DEPTH-1, so non-power-of-two depths never alias.
package line_buf_pkg;

    localparam int LINE_W = 640;
    localparam int PIX_W  = 8;

    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/line_fifo_ram.sv
// Simple dual-port line storage: one write port, one read port.
// Latency: 1-cycle registered read, or 0-cycle combinational read when LINE_FIFO_FWFT_EN is defined.
// Backpressure: none; the caller only issues accepted accesses.
module line_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage itself is never reset so it can map onto RAM primitives.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

`ifdef LINE_FIFO_FWFT_EN
    logic w_unused_ok;
    assign w_unused_ok = i_rst_n ^ i_clr ^ i_rd_en;
    assign o_rd_dat    = r_mem[i_rd_addr];
`else
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_rd_en) begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_q;
`endif

endmodule

// File: rtl/line_fifo.sv
// Parametrised single-clock pixel line FIFO with occupancy, thresholds and sticky error flags.
// Latency: 1-cycle read (0 with LINE_FIFO_FWFT_EN defined); flags decode the count register directly.
// Backpressure: writes accepted when not full or when a read frees a slot; rejected accesses set sticky flags.
module line_fifo
    import line_buf_pkg::*;
#(
    parameter int DATA_W    = PIX_W,
    parameter int DEPTH     = LINE_W,
    parameter int AFULL_TH  = 608,
    parameter int AEMPTY_TH = 32,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_ram_q;

    assign full         = (r_count == CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (32'(r_count) >= 32'(AFULL_TH));
    assign almost_empty = (32'(r_count) <= 32'(AEMPTY_TH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A read in the same cycle frees the slot, so a full FIFO still takes the write.
    assign w_rd_acc = rd_en & ~empty;
    assign w_wr_acc = wr_en & (~full | w_rd_acc);

    line_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (clr),
        .i_wr_en   (w_wr_acc & ~clr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ADDR_W'(next_ptr(32'(r_wr_ptr), 32'(DEPTH)));
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ADDR_W'(next_ptr(32'(r_rd_ptr), 32'(DEPTH)));
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef LINE_FIFO_FWFT_EN
    assign rd_valid = ~empty;
    assign data_o   = empty ? '0 : w_ram_q;
`else
    logic r_rd_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
        end else if (clr) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
        end
    end

    assign rd_valid = r_rd_valid;
    assign data_o   = w_ram_q;
`endif

endmodule

// File: tb/tb_line_fifo.sv
// Bench for line_fifo: a 640-deep instance and a 5-deep instance checked against a queue model.
module tb_line_fifo;

    localparam int DA = 640;
    localparam int DB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr;
    logic       wa, ra, wb, rb;
    logic [7:0] da, db;
    logic [7:0] doa, dob;
    logic       va, vb, fa, fb, ea, eb, afa, afb, aea, aeb, ova, ovb, una, unb;
    logic [9:0] ca;
    logic [2:0] cb;

    line_fifo #(.DATA_W(8), .DEPTH(DA), .AFULL_TH(608), .AEMPTY_TH(32)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wa), .data_in(da), .rd_en(ra),
        .data_o(doa), .rd_valid(va), .full(fa), .empty(ea), .almost_full(afa),
        .almost_empty(aea), .count(ca), .overflow(ova), .underflow(una)
    );

    line_fifo #(.DATA_W(8), .DEPTH(DB), .AFULL_TH(4), .AEMPTY_TH(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wb), .data_in(db), .rd_en(rb),
        .data_o(dob), .rd_valid(vb), .full(fb), .empty(eb), .almost_full(afb),
        .almost_empty(aeb), .count(cb), .overflow(ovb), .underflow(unb)
    );

    // Reference model: an ordered queue of stored words plus the sticky flags.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         m_ovf[2];
    bit         m_unf[2];
    bit         m_vld[2];
    logic [7:0] m_do[2];

    int checks = 0;
    int errors = 0;

    function automatic int q_size(int w);
        return (w == 0) ? qa.size() : qb.size();
    endfunction

    function automatic void m_upd(int w, bit wr, logic [7:0] d, bit rd, bit c, int depth);
        int sz;
        bit racc, wacc;
        sz = q_size(w);
        if (c) begin
            if (w == 0) qa.delete(); else qb.delete();
            m_ovf[w] = 1'b0;
            m_unf[w] = 1'b0;
            m_vld[w] = 1'b0;
            m_do[w]  = 8'h00;
            return;
        end
        racc = rd && (sz != 0);
        wacc = wr && ((sz < depth) || racc);
        if (rd && sz == 0) m_unf[w] = 1'b1;
        if (wr && !wacc)   m_ovf[w] = 1'b1;
        m_vld[w] = racc;
        if (racc) m_do[w] = (w == 0) ? qa.pop_front() : qb.pop_front();
        if (wacc) begin
            if (w == 0) qa.push_back(d); else qb.push_back(d);
        end
    endfunction

    function automatic logic [7:0] exp_do(int w);
`ifdef LINE_FIFO_FWFT_EN
        if (q_size(w) == 0) return 8'h00;
        return (w == 0) ? qa[0] : qb[0];
`else
        return m_do[w];
`endif
    endfunction

    function automatic bit exp_vld(int w);
`ifdef LINE_FIFO_FWFT_EN
        return q_size(w) != 0;
`else
        return m_vld[w];
`endif
    endfunction

    task automatic step(bit w_a, logic [7:0] d_a, bit r_a, bit w_b, logic [7:0] d_b, bit r_b, bit c);
        @(negedge clk);
        wa = w_a; da = d_a; ra = r_a;
        wb = w_b; db = d_b; rb = r_b;
        clr = c;
        @(posedge clk);
        m_upd(0, w_a, d_a, r_a, c, DA);
        m_upd(1, w_b, d_b, r_b, c, DB);
        #1;
        wa = 1'b0; ra = 1'b0; wb = 1'b0; rb = 1'b0; clr = 1'b0;
    endtask

    task automatic sa(bit w, logic [7:0] d, bit r);
        step(w, d, r, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0; clr = 1'b0;
        wa = 1'b0; ra = 1'b0; wb = 1'b0; rb = 1'b0; da = 8'h00; db = 8'h00;
        m_upd(0, 1'b0, 8'h00, 1'b0, 1'b1, DA);
        m_upd(1, 1'b0, 8'h00, 1'b0, 1'b1, DB);
        #2;
        checks++;
        if ({ca, ea, va, ova, una, doa} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_a_state: cnt/empty/vld/ovf/unf/data got %0d/%b/%b/%b/%b/%h want 0/1/0/0/0/00",
                     ca, ea, va, ova, una, doa);
        end
        checks++;
        if ({fa, afa, aea} !== 3'b001) begin
            errors++;
            $display("FAIL reset_a_flags: full/afull/aempty got %b%b%b want 001", fa, afa, aea);
        end
        checks++;
        if ({cb, eb, vb} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_b_state: cnt/empty/vld got %0d/%b/%b want 0/1/0", cb, eb, vb);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < DA; i++) begin
            sa(1'b1, 8'(i), 1'b0);
            checks++;
            if ({fa, ea, afa, aea, ova, una} !== {qa.size() == DA, qa.size() == 0, qa.size() >= 608,
                                                 qa.size() <= 32, m_ovf[0], m_unf[0]}) begin
                errors++;
                $display("FAIL fill_flags: at count %0d full/empty/af/ae/ovf/unf got %b%b%b%b%b%b",
                         qa.size(), fa, ea, afa, aea, ova, una);
            end
        end
        checks++;
        if ({fa, afa, ca} !== {1'b1, 1'b1, 10'd640}) begin
            errors++;
            $display("FAIL fill_full: full/afull/count got %b/%b/%0d want 1/1/640", fa, afa, ca);
        end
        for (int i = 0; i < DA; i++) begin
            sa(1'b0, 8'h00, 1'b1);
            checks++;
            if ({va, doa, ca} !== {exp_vld(0), exp_do(0), 10'(qa.size())}) begin
                errors++;
                $display("FAIL drain_data: read %0d vld/data/count got %b/%h/%0d want %b/%h/%0d",
                         i, va, doa, ca, exp_vld(0), exp_do(0), qa.size());
            end
`ifndef LINE_FIFO_FWFT_EN
            checks++;
            if (doa !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order: read %0d got %h want %h", i, doa, 8'(i));
            end
`endif
        end
        checks++;
        if ({ea, aea, fa} !== 3'b110) begin
            errors++;
            $display("FAIL drain_empty: empty/aempty/full got %b%b%b want 110", ea, aea, fa);
        end
        sa(1'b0, 8'h00, 1'b0);
        checks++;
        if ({va, doa} !== {exp_vld(0), exp_do(0)}) begin
            errors++;
            $display("FAIL idle_hold: vld/data got %b/%h want %b/%h", va, doa, exp_vld(0), exp_do(0));
        end
    endtask

    task automatic test_overflow_underflow;
        for (int i = 0; i <= DA; i++) begin
            sa(1'b1, 8'($urandom()), 1'b0);
            checks++;
            if ({ova, ca} !== {m_ovf[0], 10'(qa.size())}) begin
                errors++;
                $display("FAIL ovf_fill: write %0d ovf/count got %b/%0d want %b/%0d",
                         i, ova, ca, m_ovf[0], qa.size());
            end
        end
        checks++;
        if ({ova, ca} !== {1'b1, 10'd640}) begin
            errors++;
            $display("FAIL ovf_set: ovf/count got %b/%0d want 1/640", ova, ca);
        end
        for (int i = 0; i < DA; i++) begin
            sa(1'b0, 8'h00, 1'b1);
            checks++;
            if ({va, doa} !== {exp_vld(0), exp_do(0)}) begin
                errors++;
                $display("FAIL ovf_drain: read %0d vld/data got %b/%h want %b/%h",
                         i, va, doa, exp_vld(0), exp_do(0));
            end
        end
        sa(1'b0, 8'h00, 1'b1);
        checks++;
        if ({una, ova, ca, va} !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL unf_set: unf/ovf/count/vld got %b/%b/%0d/%b want 1/1/0/0", una, ova, ca, va);
        end
        for (int i = 0; i < 3; i++) sa(1'b0, 8'h00, 1'b0);
        checks++;
        if ({una, ova} !== 2'b11) begin
            errors++;
            $display("FAIL sticky_hold: unf/ovf got %b%b want 11", una, ova);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({una, ova, ea} !== 3'b001) begin
            errors++;
            $display("FAIL sticky_clr: unf/ovf/empty got %b%b%b want 001", una, ova, ea);
        end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < DA; i++) sa(1'b1, 8'($urandom()), 1'b0);
        for (int i = 0; i < 10; i++) begin
            sa(1'b1, 8'($urandom()), 1'b1);
            checks++;
            if ({ca, ova, fa, va, doa} !== {10'd640, 1'b0, 1'b1, exp_vld(0), exp_do(0)}) begin
                errors++;
                $display("FAIL simul_full: cyc %0d count/ovf/full/vld/data got %0d/%b/%b/%b/%h want 640/0/1/%b/%h",
                         i, ca, ova, fa, va, doa, exp_vld(0), exp_do(0));
            end
        end
        for (int i = 0; i < DA; i++) begin
            sa(1'b0, 8'h00, 1'b1);
            checks++;
            if ({va, doa} !== {exp_vld(0), exp_do(0)}) begin
                errors++;
                $display("FAIL simul_drain: read %0d vld/data got %b/%h want %b/%h",
                         i, va, doa, exp_vld(0), exp_do(0));
            end
        end
        sa(1'b1, 8'h3C, 1'b1);
        checks++;
        if ({ca, una, ova, va} !== {10'd1, 1'b1, 1'b0, exp_vld(0)}) begin
            errors++;
            $display("FAIL simul_empty: count/unf/ovf/vld got %0d/%b/%b/%b want 1/1/0/%b",
                     ca, una, ova, va, exp_vld(0));
        end
        sa(1'b0, 8'h00, 1'b1);
`ifndef LINE_FIFO_FWFT_EN
        checks++;
        if ({va, doa, ea} !== {1'b1, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL simul_readback: vld/data/empty got %b/%h/%b want 1/3c/1", va, doa, ea);
        end
`else
        checks++;
        if (ea !== 1'b1) begin
            errors++;
            $display("FAIL simul_readback: empty got %b want 1", ea);
        end
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_flush;
        sa(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 100; i++) sa(1'b1, 8'($urandom()), 1'b0);
        sa(1'b1, 8'h55, 1'b1);
        checks++;
        if ({ca, una} !== {10'd100, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: count/unf got %0d/%b want 100/1", ca, una);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        m_upd(0, 1'b0, 8'h00, 1'b0, 1'b1, DA);
        m_upd(1, 1'b0, 8'h00, 1'b0, 1'b1, DB);
        #1;
        checks++;
        if ({ca, ea, va, ova, una, doa} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: cnt/empty/vld/ovf/unf/data got %0d/%b/%b/%b/%b/%h want 0/1/0/0/0/00",
                     ca, ea, va, ova, una, doa);
        end
        @(negedge clk);
        rst = 1'b1;
        sa(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 100; i++) sa(1'b1, 8'($urandom()), 1'b0);
        sa(1'b1, 8'h66, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({ca, ea, va, ova, una, doa} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL sync_clr: cnt/empty/vld/ovf/unf/data got %0d/%b/%b/%b/%b/%h want 0/1/0/0/0/00",
                     ca, ea, va, ova, una, doa);
        end
        sa(1'b1, 8'h11, 1'b0);
        sa(1'b0, 8'h00, 1'b1);
        checks++;
        if ({va, doa, ca} !== {exp_vld(0), exp_do(0), 10'(qa.size())}) begin
            errors++;
            $display("FAIL post_clr_rw: vld/data/count got %b/%h/%0d want %b/%h/%0d",
                     va, doa, ca, exp_vld(0), exp_do(0), qa.size());
        end
    endtask

    task automatic test_wrap_small;
        int written = 0;
        int got     = 0;
        int cyc     = 0;
        bit w, r;
        logic [7:0] d;
        while (written < 23 && cyc < 400) begin
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            d = 8'($urandom());
            if (w && ((qb.size() < DB) || (r && qb.size() != 0))) written++;
            step(1'b0, 8'h00, 1'b0, w, d, r, 1'b0);
            cyc++;
            if (vb) got++;
            checks++;
            if ({vb, dob, cb, fb, eb, ovb, unb} !== {exp_vld(1), exp_do(1), 3'(qb.size()), qb.size() == DB,
                                                    qb.size() == 0, m_ovf[1], m_unf[1]}) begin
                errors++;
                $display("FAIL wrap_cycle: cyc %0d vld/data/count/full/empty/ovf/unf got %b/%h/%0d/%b/%b/%b/%b want %b/%h/%0d",
                         cyc, vb, dob, cb, fb, eb, ovb, unb, exp_vld(1), exp_do(1), qb.size());
            end
        end
        checks++;
        if (written < 23) begin
            errors++;
            $display("FAIL wrap_budget: wrote %0d words want 23", written);
        end
        for (int i = 0; i < 8 && qb.size() != 0; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            if (vb) got++;
            checks++;
            if ({vb, dob, cb} !== {exp_vld(1), exp_do(1), 3'(qb.size())}) begin
                errors++;
                $display("FAIL wrap_drain: vld/data/count got %b/%h/%0d want %b/%h/%0d",
                         vb, dob, cb, exp_vld(1), exp_do(1), qb.size());
            end
        end
`ifndef LINE_FIFO_FWFT_EN
        checks++;
        if (got != written) begin
            errors++;
            $display("FAIL wrap_total: words out %0d want %0d", got, written);
        end
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

`ifdef LINE_FIFO_FWFT_EN
    task automatic test_fwft;
        sa(1'b1, 8'hA5, 1'b0);
        checks++;
        if ({doa, va} !== {8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL fwft_show: data/vld got %h/%b want a5/1", doa, va);
        end
        sa(1'b0, 8'h00, 1'b1);
        checks++;
        if ({ea, va} !== 2'b10) begin
            errors++;
            $display("FAIL fwft_ack: empty/vld got %b%b want 10", ea, va);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_reset_flush();
        test_wrap_small();
`ifdef LINE_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
